// File: rtl/demux_1to2_stream_pkg.sv
// Shared constants and helpers for the 1:2 stream demultiplexer.
package demux_1to2_stream_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Occupancy needs one extra bit so that full (== DEPTH) and empty (== 0) differ.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Single-clock FIFO used as the per-channel output buffer of the demux.
module demux_fifo
  import demux_1to2_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              do_push;
  logic              do_pop;

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; the empty flag masks any stale contents.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to2_stream.sv
// Steers one valid/ready stream into two FIFO-buffered channels with debug word counts.
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              sel_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  input  logic              a_ready_in,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  input  logic              b_ready_in,
  input  logic              clr_count_in,
  output logic [CNT_W-1:0]  a_count_out,
  output logic [CNT_W-1:0]  b_count_out
);

  logic a_full;
  logic a_empty;
  logic b_full;
  logic b_empty;
  logic push_a;
  logic push_b;
  logic pop_a;
  logic pop_b;

  // Readiness ignores same-cycle pops: a full channel never passes a word through.
  assign ready_out = ~rst_in & ((sel_in == SEL_A) ? ~a_full : ~b_full);

  assign push_a = valid_in & ready_out & (sel_in == SEL_A);
  assign push_b = valid_in & ready_out & (sel_in == SEL_B);

  assign a_valid_out = ~a_empty;
  assign b_valid_out = ~b_empty;
  assign pop_a       = a_valid_out & a_ready_in;
  assign pop_b       = b_valid_out & b_ready_in;

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_a (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (push_a),
    .pop    (pop_a),
    .wdata  (d_in),
    .rdata  (a_out),
    .full   (a_full),
    .empty  (a_empty)
  );

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_b (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (push_b),
    .pop    (pop_b),
    .wdata  (d_in),
    .rdata  (b_out),
    .full   (b_full),
    .empty  (b_empty)
  );

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_count_in) begin
      a_count_out <= '0;
      b_count_out <= '0;
    end else begin
      if (push_a && (a_count_out != '1)) begin
        a_count_out <= a_count_out + CNT_W'(1);
      end
      if (push_b && (b_count_out != '1)) begin
        b_count_out <= b_count_out + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Scoreboard bench: queue model of both channels, checked on every falling edge.
module tb_demux_1to2_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d;
  logic          sel;
  logic          valid;
  logic          ready;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready;
  logic          clr;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            ca;
  int            cb;
  bit            model_ready = 1'b0;
  bit            accepted    = 1'b0;

  always #5 clk = ~clk;

  demux_1to2_stream #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .d_in         (d),
    .sel_in       (sel),
    .valid_in     (valid),
    .ready_out    (ready),
    .a_out        (a_data),
    .a_valid_out  (a_valid),
    .a_ready_in   (a_ready),
    .b_out        (b_data),
    .b_valid_out  (b_valid),
    .b_ready_in   (b_ready),
    .clr_count_in (clr),
    .a_count_out  (a_count),
    .b_count_out  (b_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then retire words the consumer takes.
  always @(negedge clk) begin
    model_ready = !rst && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    chk("ready", 32'(ready), 32'(model_ready));
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("a_data", 32'(a_data), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    chk("b_data", 32'(b_data), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
    chk("a_count", 32'(a_count), 32'(ca));
    chk("b_count", 32'(b_count), 32'(cb));
    if (!rst) begin
      if (qa.size() != 0 && a_ready) void'(qa.pop_front());
      if (qb.size() != 0 && b_ready) void'(qb.pop_front());
    end
  end

  // Predictor: record accepted words at the clock edge.
  always @(posedge clk) begin
    accepted = 1'b0;
    if (rst) begin
      qa.delete();
      qb.delete();
      ca = 0;
      cb = 0;
    end else begin
      if (valid && model_ready) begin
        accepted = 1'b1;
        if (sel) qb.push_back(d);
        else     qa.push_back(d);
      end
      if (clr) begin
        ca = 0;
        cb = 0;
      end else if (accepted) begin
        if (sel) cb = (cb < CMAX) ? cb + 1 : cb;
        else     ca = (ca < CMAX) ? ca + 1 : ca;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send(input logic [DW-1:0] w, input logic s);
    bit done = 1'b0;
    valid = 1'b1;
    d     = w;
    sel   = s;
    for (int i = 0; i < 50 && !done; i++) begin
      cyc();
      done = accepted;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout actual=not_accepted required=accepted word=%0h", w);
    end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; d = 8'h05; sel = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; clr = 1'b0;
    repeat (2) cyc();
    rst = 1'b0; valid = 1'b0;
    idle(1);

    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    idle(3);

    // Back-pressure on A while B keeps flowing.
    a_ready = 1'b0;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    valid = 1'b1; d = 8'hA2; sel = 1'b0;
    repeat (3) cyc();
    valid = 1'b0;
    send(8'hB0, 1'b1);
    a_ready = 1'b1;
    send(8'hA2, 1'b0);
    idle(4);

    // Push and pop A together with one word resident.
    a_ready = 1'b0;
    send(8'h30, 1'b0);
    a_ready = 1'b1;
    valid = 1'b1; sel = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      d = 8'(8'h30 + i);
      cyc();
    end
    idle(3);

    // Saturation at 15, then clear colliding with a push.
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i), 1'b1);
    idle(2);
    clr = 1'b1; valid = 1'b1; d = 8'h77; sel = 1'b1;
    cyc();
    clr = 1'b0;
    idle(3);

    // Reset with both channels holding words.
    a_ready = 1'b0; b_ready = 1'b0;
    send(8'hC0, 1'b0); send(8'hC1, 1'b0);
    send(8'hD0, 1'b1); send(8'hD1, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    idle(4);

    // Random traffic, holding the word while it is stalled.
    for (int i = 0; i < 600; i++) begin
      if (!(valid && !accepted)) begin
        valid = ($urandom_range(0, 3) != 0);
        d     = 8'($urandom);
        sel   = 1'($urandom);
      end
      a_ready = ($urandom_range(0, 2) != 0);
      b_ready = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 40) == 0);
      cyc();
    end
    clr = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
